// File: rtl/exec_writeback.sv
// exec_writeback: execute/writeback stage; single-cycle ALU ops plus one shared fixed-latency divider
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_dispatch_threads    thread picked per ALU slot (>= NUM_THREADS means idle)
//   i_op_in, i_rs1_val, i_rs2_val, i_rd_in   per-thread pending instruction
//   o_issue_ack           combinational per-thread consume strobe
//   o_wb_valid, o_wb_rd, o_wb_data           registered per-thread writeback
//   o_div_busy            divider occupied
//   o_dispatch_err        sticky illegal-dispatch flag
module exec_writeback #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_ALUS    = 1,
    parameter int XLEN        = 32,
    parameter int DIV_LAT     = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_ALUS-1:0][2:0]           i_dispatch_threads,
    input  logic [NUM_THREADS-1:0][6:0]        i_op_in,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]   i_rs1_val,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]   i_rs2_val,
    input  logic [NUM_THREADS-1:0][4:0]        i_rd_in,
    output logic [NUM_THREADS-1:0]             o_issue_ack,
    output logic [NUM_THREADS-1:0]             o_wb_valid,
    output logic [NUM_THREADS-1:0][4:0]        o_wb_rd,
    output logic [NUM_THREADS-1:0][XLEN-1:0]   o_wb_data,
    output logic                               o_div_busy,
    output logic                               o_dispatch_err
);
    localparam int TIW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int CW  = $clog2(DIV_LAT + 1);
    localparam logic [2:0] NT = 3'(NUM_THREADS);
    localparam logic [6:0] OP_DIV = 7'd38;
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t                           r_state, w_state_n;
    logic [CW-1:0]                    r_cnt, w_cnt_n;
    logic [XLEN-1:0]                  r_div_a, r_div_b, w_div_q;
    logic [4:0]                       r_div_rd;
    logic [TIW-1:0]                   r_div_thr, w_div_thr, w_ti;
    logic                             w_div_take, w_div_done, w_err, r_err;
    logic [NUM_THREADS-1:0]           w_seen, w_alu_v, w_div_wb, r_wb_valid;
    logic [NUM_THREADS-1:0][4:0]      r_wb_rd;
    logic [NUM_THREADS-1:0][XLEN-1:0] w_alu_res, r_wb_data;

    function automatic logic [XLEN-1:0] f_alu(input logic [6:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (op)
            7'd1:    return a + b;
            7'd2:    return a - b;
            7'd3:    return a & b;
            7'd4:    return a | b;
            7'd5:    return a ^ b;
            7'd6:    return a << b[4:0];
            7'd7:    return a >> b[4:0];
            7'd8:    return $signed(a) >>> b[4:0];
            7'd9:    return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            7'd10:   return {{(XLEN-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

    // Slots scanned lowest first so the lower slot wins on a duplicate thread
    always_comb begin
        w_seen     = '0;
        w_alu_v    = '0;
        w_div_take = 1'b0;
        w_div_thr  = '0;
        w_err      = 1'b0;
        w_ti       = '0;
        for (int j = 0; j < NUM_ALUS; j++) begin
            w_ti = i_dispatch_threads[j][TIW-1:0];
            if (i_dispatch_threads[j] < NT && i_op_in[w_ti] != 7'd0) begin
                if (w_seen[w_ti]) begin
                    w_err = 1'b1;
                end else begin
                    w_seen[w_ti] = 1'b1;
                    if (i_op_in[w_ti] == OP_DIV) begin
                        if (r_state == S_BUSY || w_div_take) begin
                            w_err = 1'b1;
                        end else begin
                            w_div_take = 1'b1;
                            w_div_thr  = w_ti;
                        end
                    end else begin
                        w_alu_v[w_ti] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        assign w_alu_res[t] = f_alu(i_op_in[t], i_rs1_val[t], i_rs2_val[t]);
        assign w_div_wb[t]  = w_div_done && r_div_thr == TIW'(t);
        assign o_issue_ack[t] = !i_rst && (w_alu_v[t] || (w_div_take && w_div_thr == TIW'(t)));
    end

    // Quotient is combinational over operands held for the whole busy window
    assign w_div_q = (r_div_b == '0) ? '1 :
                     (r_div_a == {1'b1, {(XLEN-1){1'b0}}} && r_div_b == '1) ? r_div_a :
                     $unsigned($signed(r_div_a) / $signed(r_div_b));
    assign w_div_done = r_state == S_BUSY && r_cnt == CW'(1);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        if (r_state == S_IDLE) begin
            if (w_div_take) begin
                w_state_n = S_BUSY;
                w_cnt_n   = CW'(DIV_LAT - 1);
            end
        end else begin
            w_cnt_n   = r_cnt - CW'(1);
            w_state_n = w_div_done ? S_IDLE : S_BUSY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_div_rd  <= '0;
            r_div_thr <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_div_take) begin
                r_div_a   <= i_rs1_val[w_div_thr];
                r_div_b   <= i_rs2_val[w_div_thr];
                r_div_rd  <= i_rd_in[w_div_thr];
                r_div_thr <= w_div_thr;
            end
        end
    end

    // A divider result colliding with an ALU result on one thread wins and flags an error
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_valid <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= w_alu_v | w_div_wb;
            r_err      <= r_err | w_err | |(w_alu_v & w_div_wb);
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_div_wb[t]) begin
                    r_wb_rd[t]   <= r_div_rd;
                    r_wb_data[t] <= w_div_q;
                end else if (w_alu_v[t]) begin
                    r_wb_rd[t]   <= i_rd_in[t];
                    r_wb_data[t] <= w_alu_res[t];
                end
            end
        end
    end

    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_div_busy     = r_state == S_BUSY;
    assign o_dispatch_err = r_err;
endmodule
